// File: rtl/fetch_icache.sv
// Direct-mapped instruction cache for the fetch stage. Misses refill the
// whole line from word 0, one word request outstanding at a time.
module fetch_icache #(
  parameter int unsigned LINES = 16,
  parameter int unsigned WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [31:0] req_address,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [31:0] resp_address,
  input  logic        resp_ready,
  input  logic        invalidate,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_address,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int unsigned OFF_W = $clog2(WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP} state_t;

  state_t            state_q;
  logic [31:0]       addr_q;
  logic [31:0]       resp_data_q;
  logic [OFF_W-1:0]  cnt_q;
  logic [LINES-1:0]  valid_q;
  logic              inv_seen_q;

  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [31:0]       data_mem [LINES*WORDS];

  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              last_word;
  logic              refill_beat;

  assign off         = addr_q[2 +: OFF_W];
  assign idx         = addr_q[2 + OFF_W +: IDX_W];
  assign tag         = addr_q[31 -: TAG_W];
  assign hit         = valid_q[idx] && (tag_mem[idx] == tag);
  assign last_word   = (cnt_q == OFF_W'(WORDS - 1));
  assign refill_beat = (state_q == MEM_WAIT) && mem_resp_valid;

  assign req_ready       = (state_q == IDLE);
  assign resp_valid      = (state_q == RESP);
  assign resp_data       = resp_data_q;
  assign resp_address    = addr_q;
  assign mem_req_valid   = (state_q == MEM_REQ);
  assign mem_req_address = {addr_q[31:2+OFF_W], cnt_q, 2'b00};

  // Control FSM, valid bits and response register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      resp_data_q <= '0;
      cnt_q       <= '0;
      valid_q     <= '0;
      inv_seen_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q  <= req_address;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            resp_data_q <= data_mem[{idx, off}];
            state_q     <= RESP;
          end else begin
            cnt_q      <= '0;
            inv_seen_q <= 1'b0;
            state_q    <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (invalidate) inv_seen_q <= 1'b1;
          if (mem_req_ready) state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (invalidate) inv_seen_q <= 1'b1;
          if (mem_resp_valid) begin
            if (cnt_q == off) resp_data_q <= mem_resp_data;
            cnt_q <= cnt_q + 1'b1;
            if (last_word) begin
              // A fence.i seen anywhere in this refill keeps the line invalid.
              if (!inv_seen_q && !invalidate) valid_q[idx] <= 1'b1;
              state_q <= RESP;
            end else begin
              state_q <= MEM_REQ;
            end
          end
        end
        RESP: begin
          if (resp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // Invalidate overrides any valid-bit set made above in the same cycle.
      if (invalidate) valid_q <= '0;
    end
  end

  // Data and tag arrays: written during refill, no reset needed.
  always_ff @(posedge clk) begin
    if (!reset && refill_beat) begin
      data_mem[{idx, cnt_q}] <= mem_resp_data;
      if (last_word) tag_mem[idx] <= tag;
    end
  end

endmodule

// File: doc/fetch_icache.md
FETCH_ICACHE -- requirements
Module: fetch_icache

Interface
REQ-001 The block SHALL have parameter LINES, default 16, meaning the number of direct-mapped cache lines (power of two).
REQ-002 The block SHALL have parameter WORDS, default 4, meaning the number of 32-bit words per line (power of two).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: fetch presents a request.
REQ-006 The block SHALL have port req_address, input, 32 bits: fetch address.
REQ-007 The block SHALL have port req_ready, output, 1 bit: cache accepts a request.
REQ-008 The block SHALL have port resp_valid, output, 1 bit: response word valid.
REQ-009 The block SHALL have port resp_data, output, 32 bits: instruction word.
REQ-010 The block SHALL have port resp_address, output, 32 bits: address of resp_data.
REQ-011 The block SHALL have port resp_ready, input, 1 bit: fetch consumes the response.
REQ-012 The block SHALL have port invalidate, input, 1 bit: clear all valid bits (fence.i).
REQ-013 The block SHALL have port mem_req_valid, output, 1 bit: word read request to memory.
REQ-014 The block SHALL have port mem_req_address, output, 32 bits: word-aligned memory address.
REQ-015 The block SHALL have port mem_req_ready, input, 1 bit: memory accepts the request.
REQ-016 The block SHALL have port mem_resp_valid, input, 1 bit: memory returns one word.
REQ-017 The block SHALL have port mem_resp_data, input, 32 bits: returned word.

Function
REQ-018 Address split SHALL be: bits[1:0] ignored; word offset = bits[2 +: log2(WORDS)]; index = next log2(LINES) bits; tag = remaining upper bits (defaults: offset [3:2], index [7:4], tag [31:8]).
REQ-019 The FSM SHALL have states IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 On req_valid && req_ready, the block SHALL latch req_address and go to LOOKUP.
REQ-021 In LOOKUP, hit (line valid && tag match) SHALL load the word into the response register and go to RESP; a miss SHALL clear the refill counter and go to MEM_REQ.
REQ-022 Hit latency SHALL be exactly 2 cycles: handshake in cycle N, resp_valid high in cycle N+2.
REQ-023 In MEM_REQ, mem_req_valid SHALL be 1 with mem_req_address = {tag, index, counter, 2'b00}; on mem_req_ready, go to MEM_WAIT.
REQ-024 Only one memory request SHALL be outstanding; in MEM_WAIT, mem_resp_valid SHALL write mem_resp_data to data[index][counter] and, if counter == offset, capture it into the response register.
REQ-025 After each word, counter SHALL increment; on the last word (counter == WORDS-1), the block SHALL write the tag, set the valid bit, and go to RESP; otherwise go to MEM_REQ.
REQ-026 Refill SHALL start at word 0 regardless of the requested offset (no critical-word-first).
REQ-027 In RESP, resp_valid SHALL be 1 with resp_address = latched address; resp_data and resp_address SHALL stay stable until resp_ready, then the block SHALL go to IDLE.
REQ-028 mem_resp_valid outside MEM_WAIT SHALL be ignored.
REQ-029 invalidate SHALL clear every valid bit at the next edge, in any state.
REQ-030 If invalidate is asserted at any time during a refill (MEM_REQ/MEM_WAIT), the refill SHALL complete and deliver its response, but the line SHALL NOT be marked valid.
REQ-031 If invalidate and the final refill word coincide, the line SHALL remain invalid.

Reset
REQ-032 Reset SHALL clear all valid bits and the refill counter and put the FSM in IDLE; after reset, req_ready=1, resp_valid=0, mem_req_valid=0, and resp_data=0, resp_address=0.
REQ-033 Reset asserted mid-refill or in RESP SHALL abandon the transaction; later mem_resp_valid SHALL be ignored; the data array SHALL NOT need reset.

Verification
REQ-034 Cold miss: reset, request 0x0000_0108, memory returns 0xA0..0xA3 for 0x100..0x10C with mem_req_ready=1 and 1-cycle latency -> four mem requests 0x100,0x104,0x108,0x10C in order; resp_data=0xA2, resp_address=0x108.
REQ-035 Hit after fill: request 0x0000_010C -> no mem_req_valid; resp_valid at handshake+2 with resp_data=0xA3.
REQ-036 Conflict: fill 0x100, then request 0x0000_1100 (same index 0, different tag) -> refill; a subsequent request to 0x100 misses again.
REQ-037 Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid, resp_data and resp_address stable; req_ready=0 throughout.
REQ-038 invalidate pulse during the second refill word of 0x200 -> the response is still delivered; a repeat request to 0x200 misses.
REQ-039 Reset in MEM_WAIT, then a stray mem_resp_valid -> FSM in IDLE, no resp_valid, no line valid.
